// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light controller and its monitor:
// phase encoding, fault codes and default phase durations.
package traffic_pkg;

    typedef enum logic [2:0] {
        PhMainGreen  = 3'd0,
        PhMainYellow = 3'd1,
        PhWalk       = 3'd2,
        PhSideGreen  = 3'd3,
        PhSideYellow = 3'd4,
        PhUnknown    = 3'd7
    } phase_e;

    localparam logic [2:0] FaultNone      = 3'd0;
    localparam logic [2:0] FaultMainHot   = 3'd1;
    localparam logic [2:0] FaultSideHot   = 3'd2;
    localparam logic [2:0] FaultConflict  = 3'd3;
    localparam logic [2:0] FaultWalk      = 3'd4;
    localparam logic [2:0] FaultIllegal   = 3'd5;
    localparam logic [2:0] FaultTooShort  = 3'd6;
    localparam logic [2:0] FaultTooLong   = 3'd7;

    // Default durations in seconds, shared with the controller.
    localparam int unsigned DefMainGreenS = 6;
    localparam int unsigned DefSideGreenS = 3;
    localparam int unsigned DefYellowS    = 2;
    localparam int unsigned DefWalkS      = 3;
    localparam int unsigned DefExtS       = 3;
    localparam int unsigned DefTol        = 1;

    function automatic logic is_one_hot3(logic [2:0] v);
        return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
    endfunction

    // Normal sequence; UNKNOWN handling is left to the caller.
    function automatic logic step_is_legal(logic [2:0] from_ph, logic [2:0] to_ph);
        logic legal;
        legal = 1'b0;
        case (from_ph)
            PhMainGreen:  legal = (to_ph == PhMainYellow);
            PhMainYellow: legal = (to_ph == PhWalk) || (to_ph == PhSideGreen);
            PhWalk:       legal = (to_ph == PhSideGreen);
            PhSideGreen:  legal = (to_ph == PhSideYellow);
            PhSideYellow: legal = (to_ph == PhMainGreen);
            default:      legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/light_phase_decoder.sv
// Combinational decode of the seven light signals into a phase plus the
// four illegal-light condition flags.
module light_phase_decoder
    import traffic_pkg::*;
(
    input  logic       main_green,
    input  logic       main_yellow,
    input  logic       main_red,
    input  logic       side_green,
    input  logic       side_yellow,
    input  logic       side_red,
    input  logic       walk_light,
    output logic [2:0] phase,
    output logic       main_not_hot,
    output logic       side_not_hot,
    output logic       no_red,
    output logic       walk_unsafe
);

    logic [6:0] lights;

    assign lights = {main_green, main_yellow, main_red,
                     side_green, side_yellow, side_red, walk_light};

    // Exact pattern match: any extra or missing lamp decodes to UNKNOWN.
    always_comb begin
        phase = PhUnknown;
        case (lights)
            7'b100_001_0: phase = PhMainGreen;
            7'b010_001_0: phase = PhMainYellow;
            7'b001_100_0: phase = PhSideGreen;
            7'b001_010_0: phase = PhSideYellow;
            7'b001_001_1: phase = PhWalk;
            default:      phase = PhUnknown;
        endcase
    end

    // Illegal light conditions, evaluated independently of the phase decode.
    always_comb begin
        main_not_hot = !is_one_hot3({main_green, main_yellow, main_red});
        side_not_hot = !is_one_hot3({side_green, side_yellow, side_red});
        no_red       = !main_red && !side_red;
        walk_unsafe  = walk_light && !(main_red && side_red);
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive monitor for the traffic light controller outputs: tracks the phase,
// times it in 1 Hz ticks and latches sequence, timing and light faults.
module traffic_light_monitor
    import traffic_pkg::*;
#(
    parameter int unsigned MAIN_GREEN_S = DefMainGreenS,
    parameter int unsigned SIDE_GREEN_S = DefSideGreenS,
    parameter int unsigned YELLOW_S     = DefYellowS,
    parameter int unsigned WALK_S       = DefWalkS,
    parameter int unsigned EXT_S        = DefExtS,
    parameter int unsigned TOL          = DefTol
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       new_clk,
    input  logic       main_green,
    input  logic       main_yellow,
    input  logic       main_red,
    input  logic       side_green,
    input  logic       side_yellow,
    input  logic       side_red,
    input  logic       walk_light,
    input  logic       clear_fault,
    output logic [2:0] phase,
    output logic [5:0] sec_in_phase,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [7:0] fault_count,
    output logic [7:0] cycle_count
);

    logic [2:0] dec_phase;
    logic [3:0] light_bad;

    logic       new_clk_q,   new_clk_d;
    logic [2:0] phase_q,     phase_d;
    logic [5:0] sec_q,       sec_d;
    logic       fault_q,     fault_d;
    logic [2:0] code_q,      code_d;
    logic [7:0] fcount_q,    fcount_d;
    logic [7:0] cycles_q,    cycles_d;
    logic [3:0] light_bad_q, light_bad_d;
    logic       partial_q,   partial_d;   // current phase entered from UNKNOWN
    logic       left_unk_q,  left_unk_d;  // first exit from UNKNOWN already seen
    logic       long_q,      long_d;      // too-long already reported this phase

    logic       tick;
    logic       changed;
    logic [5:0] sec_now;
    logic [7:1] raise;
    logic [2:0] new_code;
    int         win_lo;
    int         win_hi;

    light_phase_decoder u_decoder (
        .main_green   (main_green),
        .main_yellow  (main_yellow),
        .main_red     (main_red),
        .side_green   (side_green),
        .side_yellow  (side_yellow),
        .side_red     (side_red),
        .walk_light   (walk_light),
        .phase        (dec_phase),
        .main_not_hot (light_bad[0]),
        .side_not_hot (light_bad[1]),
        .no_red       (light_bad[2]),
        .walk_unsafe  (light_bad[3])
    );

    // Duration window of the phase currently held, tolerance already applied.
    always_comb begin
        win_lo = 0;
        win_hi = 63;
        case (phase_q)
            PhMainGreen: begin
                win_lo = int'(MAIN_GREEN_S) - int'(TOL);
                win_hi = int'(MAIN_GREEN_S) + int'(EXT_S) + int'(TOL);
            end
            PhSideGreen: begin
                win_lo = int'(SIDE_GREEN_S) - int'(TOL);
                win_hi = int'(SIDE_GREEN_S) + int'(EXT_S) + int'(TOL);
            end
            PhMainYellow, PhSideYellow: begin
                win_lo = int'(YELLOW_S) - int'(TOL);
                win_hi = int'(YELLOW_S) + int'(TOL);
            end
            PhWalk: begin
                win_lo = int'(WALK_S) - int'(TOL);
                win_hi = int'(WALK_S) + int'(TOL);
            end
            default: begin
                win_lo = 0;
                win_hi = 63;
            end
        endcase
    end

    // Fault detection and next-state for phase tracking and fault latching.
    always_comb begin
        tick    = new_clk && !new_clk_q;
        changed = (dec_phase != phase_q);
        // A tick coinciding with a phase change still belongs to the old phase.
        sec_now = (tick && sec_q != 6'd63) ? sec_q + 6'd1 : sec_q;

        raise        = '0;
        raise[1]     = light_bad[0] && !light_bad_q[0];
        raise[2]     = light_bad[1] && !light_bad_q[1];
        raise[3]     = light_bad[2] && !light_bad_q[2];
        raise[4]     = light_bad[3] && !light_bad_q[3];
        if (changed) begin
            if (!(phase_q == PhUnknown && !left_unk_q) &&
                !step_is_legal(phase_q, dec_phase)) begin
                raise[5] = 1'b1;
            end
            if (phase_q != PhUnknown && !partial_q && int'(sec_now) < win_lo) begin
                raise[6] = 1'b1;
            end
        end
        if (phase_q != PhUnknown && !long_q && int'(sec_now) > win_hi) begin
            raise[7] = 1'b1;
        end

        // Scan downwards so the lowest raised code is the one kept.
        new_code = FaultNone;
        for (int i = 7; i >= 1; i--) begin
            if (raise[i]) begin
                new_code = 3'(i);
            end
        end

        new_clk_d   = new_clk;
        light_bad_d = light_bad;
        phase_d     = dec_phase;
        sec_d       = changed ? 6'd0 : sec_now;
        partial_d   = changed ? (phase_q == PhUnknown) : partial_q;
        left_unk_d  = left_unk_q || (changed && phase_q == PhUnknown);
        long_d      = changed ? 1'b0 : (long_q || raise[7]);
        cycles_d    = (changed && phase_q == PhSideYellow && dec_phase == PhMainGreen)
                      ? cycles_q + 8'd1 : cycles_q;
        fcount_d    = (|raise && fcount_q != 8'd255) ? fcount_q + 8'd1 : fcount_q;

        fault_d = fault_q;
        code_d  = code_q;
        if (clear_fault) begin
            fault_d = 1'b0;
            code_d  = FaultNone;
        end
        // A fault arriving with clear_fault is latched rather than dropped.
        if (|raise && (!fault_q || clear_fault)) begin
            fault_d = 1'b1;
            code_d  = new_code;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            new_clk_q   <= 1'b0;
            phase_q     <= PhUnknown;
            sec_q       <= '0;
            fault_q     <= 1'b0;
            code_q      <= FaultNone;
            fcount_q    <= '0;
            cycles_q    <= '0;
            light_bad_q <= '0;
            partial_q   <= 1'b0;
            left_unk_q  <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            new_clk_q   <= new_clk_d;
            phase_q     <= phase_d;
            sec_q       <= sec_d;
            fault_q     <= fault_d;
            code_q      <= code_d;
            fcount_q    <= fcount_d;
            cycles_q    <= cycles_d;
            light_bad_q <= light_bad_d;
            partial_q   <= partial_d;
            left_unk_q  <= left_unk_d;
            long_q      <= long_d;
        end
    end

    assign phase        = phase_q;
    assign sec_in_phase = sec_q;
    assign fault        = fault_q;
    assign fault_code   = code_q;
    assign fault_count  = fcount_q;
    assign cycle_count  = cycles_q;

endmodule
